// File: rtl/clk_div_meas.sv
// Measures period and high time of a slow asynchronous clock in clk cycles,
// with lock detection against the previous period and a loss-of-clock timeout.
module clk_div_meas #(
  parameter int unsigned MAX_PERIOD  = 1000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_COUNT  = 2,
  localparam int unsigned W          = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_in,
  input  logic         en,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 s, s_d;
  logic                 rise, fall;
  logic [W-1:0]         cnt, cnt_nxt, cnt_p1;
  logic [W-1:0]         hi_lat, hi_lat_nxt;
  logic [W-1:0]         prev_period, prev_period_nxt;
  logic [W-1:0]         diff;
  logic                 match;
  logic [MW-1:0]        mcnt, mcnt_nxt, mcnt_inc;
  logic                 first, first_nxt;
  logic [W-1:0]         period_nxt, high_time_nxt;
  logic                 period_valid_nxt, locked_nxt, timeout_nxt;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  assign cnt_p1   = cnt + W'(1);
  assign diff     = (cnt_p1 >= prev_period) ? (cnt_p1 - prev_period) : (prev_period - cnt_p1);
  assign match    = (32'(diff) <= TOL);
  assign mcnt_inc = (32'(mcnt) < LOCK_COUNT) ? (mcnt + MW'(1)) : mcnt;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync         <= '0;
      s_d          <= 1'b0;
      cnt          <= '0;
      hi_lat       <= '0;
      prev_period  <= '0;
      mcnt         <= '0;
      first        <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sync         <= {sync[SYNC_STAGES-2:0], clk_in};
      s_d          <= s;
      cnt          <= cnt_nxt;
      hi_lat       <= hi_lat_nxt;
      prev_period  <= prev_period_nxt;
      mcnt         <= mcnt_nxt;
      first        <= first_nxt;
      period       <= period_nxt;
      high_time    <= high_time_nxt;
      period_valid <= period_valid_nxt;
      locked       <= locked_nxt;
      timeout      <= timeout_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    hi_lat_nxt       = hi_lat;
    prev_period_nxt  = prev_period;
    mcnt_nxt         = mcnt;
    first_nxt        = first;
    period_nxt       = period;
    high_time_nxt    = high_time;
    period_valid_nxt = 1'b0;
    locked_nxt       = locked;
    timeout_nxt      = timeout;

    if (!en) begin
      // Disabling discards any measurement in flight
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      mcnt_nxt    = '0;
      locked_nxt  = 1'b0;
      timeout_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (rise) begin
            cnt_nxt     = '0;
            first_nxt   = 1'b1;
            timeout_nxt = 1'b0;
            state_nxt   = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise at the last legal count still yields a valid period
            period_nxt       = cnt_p1;
            high_time_nxt    = hi_lat;
            period_valid_nxt = 1'b1;
            prev_period_nxt  = cnt_p1;
            first_nxt        = 1'b0;
            cnt_nxt          = '0;
            if (!first) begin
              if (match) begin
                mcnt_nxt = mcnt_inc;
                if (32'(mcnt_inc) >= LOCK_COUNT) locked_nxt = 1'b1;
              end else begin
                mcnt_nxt   = '0;
                locked_nxt = 1'b0;
              end
            end
          end else begin
            if (fall) hi_lat_nxt = cnt_p1;
            if (cnt == W'(MAX_PERIOD - 1)) begin
              timeout_nxt = 1'b1;
              locked_nxt  = 1'b0;
              mcnt_nxt    = '0;
              cnt_nxt     = '0;
              state_nxt   = WAIT_EDGE;
            end else begin
              cnt_nxt = cnt_p1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_meas.sv
// Directed test of clk_div_meas: divided-clock patterns with hand-computed periods,
// lock behaviour, timeout boundaries, enable drop and mid-run reset.
module tb_clk_div_meas;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_in;
  logic         en;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  typedef struct {
    int p;
    int h;
    int l;
    int t;
  } strobe_t;

  strobe_t q[$];
  bit      seen_to;
  int      n_chk  = 0;
  int      n_fail = 0;

  always #5 clk = ~clk;

  clk_div_meas #(
    .MAX_PERIOD (1000),
    .SYNC_STAGES(2),
    .TOL        (0),
    .LOCK_COUNT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_in      (clk_in),
    .en          (en),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  // Record every strobe just after the edge that produced it
  always @(posedge clk) begin
    #1;
    if (period_valid) q.push_back('{int'(period), int'(high_time), int'(locked), int'(timeout)});
    if (timeout) seen_to = 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_cycles(input int h, input int l, input int n);
    repeat (n) begin
      @(negedge clk) clk_in = 1'b1;
      repeat (h - 1) @(negedge clk);
      @(negedge clk) clk_in = 1'b0;
      repeat (l - 1) @(negedge clk);
    end
  endtask

  task automatic check_strobes(input string tag, input int ep[$], input int eh[$], input int el[$]);
    check($sformatf("%s_count", tag), q.size(), ep.size());
    for (int i = 0; i < ep.size() && i < q.size(); i++) begin
      check($sformatf("%s_period%0d", tag, i), q[i].p, ep[i]);
      check($sformatf("%s_high%0d", tag, i), q[i].h, eh[i]);
      check($sformatf("%s_locked%0d", tag, i), q[i].l, el[i]);
      check($sformatf("%s_timeout%0d", tag, i), q[i].t, 0);
    end
    q.delete();
  endtask

  task automatic check_outputs(input string tag, input int p, input int h, input int l, input int t);
    check({tag, "_period"}, int'(period), p);
    check({tag, "_high"}, int'(high_time), h);
    check({tag, "_valid"}, int'(period_valid), 0);
    check({tag, "_locked"}, int'(locked), l);
    check({tag, "_timeout"}, int'(timeout), t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst    = 1'b1;
    en     = 1'b0;
    clk_in = 1'b0;
    seen_to = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();

    // 1) clk/4: alignment rise, then 7 strobes, locked from the 3rd
    drive_cycles(2, 2, 8);
    check_strobes("div4", {4, 4, 4, 4, 4, 4, 4}, {2, 2, 2, 2, 2, 2, 2}, {0, 0, 1, 1, 1, 1, 1});

    // 2) switch to /10: first strobe closes the last /4 period
    drive_cycles(5, 5, 5);
    check_strobes("div10", {4, 10, 10, 10, 10}, {2, 5, 5, 5, 5}, {1, 0, 0, 1, 1});

    // 3) single rise then clk_in held low until timeout
    @(negedge clk) clk_in = 1'b1;
    k = 0;
    while (!timeout && k < 1200) begin
      @(posedge clk);
      #2;
      k++;
      if (k == 5) clk_in = 1'b0;
    end
    check("to_latency", k, 1003);
    check("to_locked", int'(locked), 0);
    check_strobes("to_pre", {10}, {5}, {1});
    drive_cycles(2, 2, 3);
    check("to_cleared", int'(timeout), 0);
    check_strobes("restart", {4, 4}, {2, 2}, {0, 0});

    // 4) period 1000 is valid; period 1001 times out without a strobe
    seen_to = 1'b0;
    drive_cycles(500, 500, 2);
    drive_cycles(500, 501, 1);
    drive_cycles(2, 2, 1);
    check("max_seen_to", int'(seen_to), 1);
    check("max_to_cleared", int'(timeout), 0);
    check_strobes("max", {4, 1000, 1000}, {2, 500, 500}, {1, 0, 0});

    // 5) en=0 mid-period: no strobe, outputs hold, lock dropped
    drive_cycles(2, 2, 4);
    check_strobes("pre_en", {4, 4, 4, 4}, {2, 2, 2, 2}, {0, 0, 1, 1});
    @(negedge clk) clk_in = 1'b1;
    repeat (2) @(negedge clk);
    clk_in = 1'b0;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    q.delete();
    drive_cycles(2, 2, 2);
    check("en0_strobes", q.size(), 0);
    check_outputs("en0", 4, 2, 0, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    drive_cycles(3, 3, 3);
    check_strobes("en1", {6, 6}, {3, 3}, {0, 0});

    // 6) one-cycle reset mid-run, then the clk/4 behaviour again
    drive_cycles(2, 2, 4);
    check("pre_rst_locked", int'(locked), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_outputs("mid_rst", 0, 0, 0, 0);
    q.delete();
    drive_cycles(2, 2, 5);
    check_strobes("post_rst", {4, 4, 4, 4}, {2, 2, 2, 2}, {0, 0, 1, 1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
